// File: rtl/core_pipe_buf.sv
// core_pipe_buf -- elastic pipeline buffer between two core stages.
//
// A circular array of DEPTH entries sits between an upstream valid/ready
// producer and a downstream valid/ready consumer. The head entry is always
// presented from registered storage, so there is no combinational path
// from in_data to out_data. The buffer also provides:
//   - stall gating: holds the head and blocks pops,
//   - synchronous flush: empties the buffer at the next edge,
//   - a per-entry occupancy tap, so the hazard unit can see every
//     in-flight destination, not only the head.
//
// Parameters:
//   WIDTH     payload bits per entry (>= 1)
//   DEPTH     number of entries (>= 1, need not be a power of two)
//   REG_READY 1: in_ready depends only on registered state (plus reset)
//             0: in_ready may also look at out_ready/stall, so a full
//                buffer can accept while it pops (pass-through)
//
// Ports:
//   clk, rst            core clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake, with in_data as the payload
//   out_valid/out_ready downstream handshake, with out_data as the head
//   stall               blocks pop and suppresses out_valid
//   flush               discards all entries at the next edge
//   count               number of entries held
//   occ_valid/occ_data  per-entry valid flags and payloads, head first

module core_pipe_buf #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,
  parameter int REG_READY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DEPTH-1:0]           occ_valid,
  output logic [DEPTH*WIDTH-1:0]     occ_data
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             space_ok;
  logic             push;
  logic             pop;

  assign space_ok  = (count < CW'(DEPTH));
  assign out_valid = (count != '0) && !stall;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // in_ready is held low while rst is asserted, so the upstream never sees
  // acceptance during reset. After release it follows the registered state.
  generate
    if (REG_READY != 0) begin : g_reg_ready
      assign in_ready = !rst && space_ok;
    end else begin : g_comb_ready
      assign in_ready = !rst && (space_ok || (out_ready && !stall));
    end
  endgenerate

  // Pointer increment with an explicit wrap compare. DEPTH may be any
  // value, so power-of-two masking cannot be used.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Control state. Flush overrides any push or pop in the same cycle and
  // returns both pointers to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is deliberately left unreset. A push that coincides
  // with a flush is dropped here too, so the dropped data never lands.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

  // Occupancy tap: slot i shows the entry i places behind the head, so the
  // index wraps around the physical array. Slots beyond count carry stale
  // data; consumers qualify them with occ_valid.
  always_comb begin
    logic [PW:0] sum;
    occ_valid = '0;
    occ_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = {1'b0, rd_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(DEPTH)) sum = sum - (PW+1)'(DEPTH);
      occ_valid[i]               = (CW'(i) < count);
      occ_data[i*WIDTH +: WIDTH] = mem[sum[PW-1:0]];
    end
  end

  // Handshake sanity: never grow past DEPTH and never pop an empty buffer.
  assert property (@(posedge clk) disable iff (rst)
                   !(push && !pop && (count == CW'(DEPTH))));
  assert property (@(posedge clk) disable iff (rst)
                   !(pop && (count == '0)));

endmodule
